// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI burst RAM.
//   opcode_e    : command opcode carried in rx_data[DATA_W+1:DATA_W]
//   out_state_e : state of the single-entry read output register
package spi_ram_pkg;

  typedef enum logic [1:0] {
    SET_WADDR = 2'b00,
    WRITE     = 2'b01,
    SET_RADDR = 2'b10,
    READ      = 2'b11
  } opcode_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/spi_ram_addr_ctr.sv
// Address register with range-checked load and wrapping post-increment.
// Used once for the write pointer and once for the read pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val if it is below MEM_DEPTH
//   load_val   : candidate address
//   inc        : advance by one (only when AUTO_INC=1), MEM_DEPTH-1 wraps to 0
//   addr       : current address
//   range_err  : one-cycle pulse after a rejected load
module spi_ram_addr_ctr #(
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              range_err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

  logic in_range;

  // Compare at 32 bits: MEM_DEPTH may equal 2**ADDR_W, which ADDR_W bits cannot hold.
  assign in_range = (32'(load_val) < 32'(MEM_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      range_err <= 1'b0;
    end else begin
      range_err <= load && !in_range;
      if (load && in_range) begin
        addr <= load_val;
      end else if (inc && (AUTO_INC == 1)) begin
        addr <= (addr == LAST) ? '0 : addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_burst_ram.sv
// Command-driven RAM behind an SPI-style byte stream.
// Each rx_valid cycle carries one command: opcode in rx_data[DATA_W+1:DATA_W],
// payload in rx_data[DATA_W-1:0]. Writes go straight to memory; reads land in
// a single-entry output register drained by a valid/ready handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rx_data, rx_valid   : command input (no backpressure)
//   tx_data, tx_valid   : read data output register
//   tx_ready            : consumer accepts tx_data
//   addr_err            : pulse after a rejected SET_WADDR/SET_RADDR
//   ovf_err             : pulse after a dropped READ
module spi_burst_ram
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              addr_err,
  output logic              ovf_err
);

  opcode_e           opcode;
  logic [DATA_W-1:0] payload;
  logic              do_set_w, do_write, do_set_r, do_read;
  logic              handshake, read_accept, read_drop;
  logic [ADDR_W-1:0] addr_wr, addr_rd;
  logic              werr, rerr;
  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  assign opcode  = opcode_e'(rx_data[DATA_W+1:DATA_W]);
  assign payload = rx_data[DATA_W-1:0];

  assign do_set_w = rx_valid && (opcode == SET_WADDR);
  assign do_write = rx_valid && (opcode == WRITE);
  assign do_set_r = rx_valid && (opcode == SET_RADDR);
  assign do_read  = rx_valid && (opcode == READ);

  // Handshake: a word transfers in any cycle where tx_valid && tx_ready; tx_data
  // and tx_valid are held stable otherwise. A READ may refill the register in the
  // same cycle its previous word is taken.
  assign handshake   = tx_valid && tx_ready;
  assign read_accept = do_read && ((state_q == EMPTY) || handshake);
  assign read_drop   = do_read && !read_accept;

  spi_ram_addr_ctr #(
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH),
    .AUTO_INC (AUTO_INC)
  ) u_wr_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (do_set_w),
    .load_val (payload[ADDR_W-1:0]),
    .inc      (do_write),
    .addr     (addr_wr),
    .range_err(werr)
  );

  spi_ram_addr_ctr #(
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH),
    .AUTO_INC (AUTO_INC)
  ) u_rd_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (do_set_r),
    .load_val (payload[ADDR_W-1:0]),
    .inc      (read_accept),
    .addr     (addr_rd),
    .range_err(rerr)
  );

  // Both counters emit registered pulses; only one command per cycle, so at most one fires.
  assign addr_err = werr | rerr;

  // Memory words are flops so reset can clear them all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[addr_wr] <= payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      tx_data <= '0;
      ovf_err <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_err <= read_drop;
      if (read_accept) tx_data <= mem[addr_rd];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (read_accept) state_d = FULL;
      FULL:  if (handshake && !read_accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  assign tx_valid = (state_q == FULL);

endmodule
